mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mips32_pkg.sv | 31 +++
 rtl/mem_port_arbiter.sv | 119 +++++++++++
 tb/tb_mem_port_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips32_pkg.sv
// Shared MIPS32 core constants: instruction-type decode values plus the
// memory-port arbiter state and response-owner encodings.
package mips32_pkg;

    localparam int unsigned DATA_W = 32;

    // Primary opcodes used by the decoder
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [1:0] {
        ITYPE_R = 2'd0,
        ITYPE_I = 2'd1,
        ITYPE_J = 2'd2
    } instr_type_e;

    // Arbiter FSM states
    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    // Owner of the response returning from memory next cycle
    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_IF   = 2'd1;
    localparam logic [1:0] OWN_D    = 2'd2;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data requests onto one single-port synchronous memory,
// with starvation relief for fetch, flush cancellation and a halt/drain FSM.
module mem_port_arbiter
    import mips32_pkg::*;
#(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    input  logic              flush,
    input  logic              halt,
    output logic              halted,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [1:0] STARVE_LIM = 2'(STARVE_MAX);

    logic [1:0]        state_q, state_d;
    logic [1:0]        owner_q, owner_d;
    logic              d_we_q, d_we_d;
    logic [1:0]        starve_q, starve_d;
    logic [DATA_W-1:0] if_rdata_q, d_rdata_q;

    logic gnt_en;
    logic fetch_wins;

    // Grant selection and memory strobe; held off in reset, outside RUN and on halt
    always_comb begin
        gnt_en     = rst_n && (state_q == ST_RUN) && !halt;
        fetch_wins = if_req && !flush && (!d_req || (starve_q == STARVE_LIM));
        if_gnt     = gnt_en && fetch_wins;
        d_gnt      = gnt_en && d_req && !fetch_wins;
        mem_en     = if_gnt || d_gnt;
        mem_we     = d_gnt && d_we;
        mem_addr   = '0;
        mem_wdata  = '0;
        if (d_gnt) begin
            mem_addr  = d_addr;
            mem_wdata = d_we ? d_wdata : '0;
        end else if (if_gnt) begin
            mem_addr = if_addr;
        end
    end

    // Responses come straight from memory; rdata holds when rvalid is low
    always_comb begin
        if_rvalid = (owner_q == OWN_IF) && !flush;
        d_rvalid  = (owner_q == OWN_D);
        if_rdata  = if_rvalid ? mem_rdata : if_rdata_q;
        d_rdata   = d_rdata_q;
        if (d_rvalid) begin
            d_rdata = d_we_q ? '0 : mem_rdata;
        end
        halted = (state_q == ST_HALT);
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        owner_d  = OWN_NONE;
        d_we_d   = d_gnt && d_we;
        starve_d = starve_q;

        if (if_gnt) begin
            owner_d = OWN_IF;
        end else if (d_gnt) begin
            owner_d = OWN_D;
        end

        if (!if_req || if_gnt) begin
            starve_d = 2'd0;
        end else if (d_gnt && (starve_q != STARVE_LIM)) begin
            starve_d = starve_q + 2'd1;
        end

        case (state_q)
            ST_RUN:   if (halt) state_d = ST_DRAIN;
            ST_DRAIN: state_d = ST_HALT;
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            owner_q    <= OWN_NONE;
            d_we_q     <= 1'b0;
            starve_q   <= 2'd0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            d_we_q     <= d_we_d;
            starve_q   <= starve_d;
            if_rdata_q <= if_rdata;
            d_rdata_q  <= d_rdata;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural single-port memory.
module tb_mem_port_arbiter;

    localparam int unsigned ADDR_W = 10;

    logic              clk;
    logic              rst_n;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [31:0]       if_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [31:0]       d_rdata;
    logic              flush;
    logic              halt;
    logic              halted;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    logic [31:0]       mem [0:1023];
    logic              bd_we;
    logic [ADDR_W-1:0] bd_addr;
    logic [31:0]       bd_data;

    int vec_cnt;
    int err_cnt;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .flush(flush), .halt(halt), .halted(halted),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port memory: read data one cycle after mem_en
    always @(posedge clk) begin
        if (bd_we) begin
            mem[bd_addr] <= bd_data;
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req  = 1'b0; if_addr = '0;
        d_req   = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        flush   = 1'b0; halt = 1'b0;
    endtask

    task automatic backdoor(input logic [ADDR_W-1:0] a, input logic [31:0] v);
        bd_we = 1'b1; bd_addr = a; bd_data = v;
        tick();
        bd_we = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        if_req = 1'b1; if_addr = 10'd3; d_req = 1'b1; d_addr = 10'd4;
        d_we = 1'b1; d_wdata = 32'h5555_AAAA;
        #2;
        vec_cnt++;
        if ({if_gnt, d_gnt, mem_en, mem_we, if_rvalid, d_rvalid, halted} !== 7'b0) begin
            err_cnt++;
            $display("FAIL reset_ctrl got %b want 0000000",
                     {if_gnt, d_gnt, mem_en, mem_we, if_rvalid, d_rvalid, halted});
        end
        vec_cnt++;
        if ({if_rdata, d_rdata, mem_addr, mem_wdata} !== '0) begin
            err_cnt++;
            $display("FAIL reset_data if_rdata=%h d_rdata=%h mem_addr=%h mem_wdata=%h want 0",
                     if_rdata, d_rdata, mem_addr, mem_wdata);
        end
        tick();
        idle_inputs();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_fetch();
        backdoor(10'd5, 32'h0000_1234);
        if_req = 1'b1; if_addr = 10'd5;
        #2;
        vec_cnt++;
        if ({if_gnt, d_gnt, mem_en, mem_we, mem_addr} !== {4'b1010, 10'd5}) begin
            err_cnt++;
            $display("FAIL fetch_grant got gnt/en/we=%b addr=%0d want 1010 addr=5",
                     {if_gnt, d_gnt, mem_en, mem_we}, mem_addr);
        end
        tick();
        if_req = 1'b0;
        #2;
        vec_cnt++;
        if ({if_rvalid, d_rvalid, if_gnt, if_rdata} !== {3'b100, 32'h0000_1234}) begin
            err_cnt++;
            $display("FAIL fetch_resp got rvalid=%b gnt=%b rdata=%h want 1 0 00001234",
                     if_rvalid, if_gnt, if_rdata);
        end
        tick();
        #2;
        vec_cnt++;
        if ({if_rvalid, if_rdata} !== {1'b0, 32'h0000_1234}) begin
            err_cnt++;
            $display("FAIL fetch_hold got rvalid=%b rdata=%h want 0 00001234", if_rvalid, if_rdata);
        end
    endtask

    task automatic test_starvation();
        logic [4:0] exp_d;
        backdoor(10'd9, 32'hCAFE_0009);
        exp_d = 5'b10111;  // cycle 0 is bit 0: D,D,D,IF,D
        if_req = 1'b1; if_addr = 10'd5;
        d_req = 1'b1; d_we = 1'b0; d_addr = 10'd9;
        for (int c = 0; c < 5; c++) begin
            #2;
            vec_cnt++;
            if ({d_gnt, if_gnt} !== {exp_d[c], ~exp_d[c]}) begin
                err_cnt++;
                $display("FAIL starve_order cycle %0d got d_gnt=%b if_gnt=%b want %b %b",
                         c, d_gnt, if_gnt, exp_d[c], ~exp_d[c]);
            end
            if (c == 4) begin
                vec_cnt++;
                if ({if_rvalid, d_rvalid, if_rdata} !== {2'b10, 32'h0000_1234}) begin
                    err_cnt++;
                    $display("FAIL starve_if_resp got if_rvalid=%b d_rvalid=%b if_rdata=%h want 1 0 00001234",
                             if_rvalid, d_rvalid, if_rdata);
                end
            end
            if (c == 1) begin
                vec_cnt++;
                if ({d_rvalid, d_rdata} !== {1'b1, 32'hCAFE_0009}) begin
                    err_cnt++;
                    $display("FAIL starve_d_resp got d_rvalid=%b d_rdata=%h want 1 cafe0009",
                             d_rvalid, d_rdata);
                end
            end
            tick();
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_store_load();
        d_req = 1'b1; d_we = 1'b1; d_addr = 10'd20; d_wdata = 32'h0000_DEAD;
        #2;
        vec_cnt++;
        if ({d_gnt, mem_en, mem_we, mem_addr, mem_wdata} !== {3'b111, 10'd20, 32'h0000_DEAD}) begin
            err_cnt++;
            $display("FAIL store_grant got gnt/en/we=%b addr=%0d wdata=%h want 111 20 0000dead",
                     {d_gnt, mem_en, mem_we}, mem_addr, mem_wdata);
        end
        tick();
        d_we = 1'b0; d_wdata = '0;
        #2;
        vec_cnt++;
        if ({d_rvalid, d_rdata, d_gnt, mem_we} !== {1'b1, 32'h0, 2'b10}) begin
            err_cnt++;
            $display("FAIL store_ack got d_rvalid=%b d_rdata=%h d_gnt=%b mem_we=%b want 1 0 1 0",
                     d_rvalid, d_rdata, d_gnt, mem_we);
        end
        tick();
        d_req = 1'b0;
        #2;
        vec_cnt++;
        if ({d_rvalid, d_rdata} !== {1'b1, 32'h0000_DEAD}) begin
            err_cnt++;
            $display("FAIL load_after_store got d_rvalid=%b d_rdata=%h want 1 0000dead", d_rvalid, d_rdata);
        end
        tick();
    endtask

    task automatic test_flush();
        backdoor(10'd6, 32'h0000_6666);
        if_req = 1'b1; if_addr = 10'd6;
        #2;
        vec_cnt++;
        if (if_gnt !== 1'b1) begin
            err_cnt++;
            $display("FAIL flush_pre_grant got if_gnt=%b want 1", if_gnt);
        end
        tick();
        flush = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 10'd9;
        #2;
        vec_cnt++;
        if ({if_gnt, if_rvalid, d_gnt, if_rdata} !== {3'b001, 32'h0000_1234}) begin
            err_cnt++;
            $display("FAIL flush_cancel got if_gnt=%b if_rvalid=%b d_gnt=%b if_rdata=%h want 0 0 1 00001234",
                     if_gnt, if_rvalid, d_gnt, if_rdata);
        end
        tick();
        idle_inputs();
        #2;
        vec_cnt++;
        if ({d_rvalid, if_rvalid, d_rdata, if_rdata} !== {2'b10, 32'hCAFE_0009, 32'h0000_1234}) begin
            err_cnt++;
            $display("FAIL flush_data_resp got d_rvalid=%b if_rvalid=%b d_rdata=%h if_rdata=%h want 1 0 cafe0009 00001234",
                     d_rvalid, if_rvalid, d_rdata, if_rdata);
        end
        tick();
    endtask

    task automatic test_halt();
        d_req = 1'b1; d_we = 1'b0; d_addr = 10'd9;
        #2;
        vec_cnt++;
        if (d_gnt !== 1'b1) begin
            err_cnt++;
            $display("FAIL halt_pre_grant got d_gnt=%b want 1", d_gnt);
        end
        tick();
        halt = 1'b1; if_req = 1'b1; if_addr = 10'd5;
        #2;
        vec_cnt++;
        if ({d_gnt, if_gnt, mem_en, d_rvalid, halted, d_rdata} !== {5'b00010, 32'hCAFE_0009}) begin
            err_cnt++;
            $display("FAIL halt_drain_resp got gnt d/if=%b%b en=%b d_rvalid=%b halted=%b d_rdata=%h want 00 0 1 0 cafe0009",
                     d_gnt, if_gnt, mem_en, d_rvalid, halted, d_rdata);
        end
        tick();
        halt = 1'b0;
        #2;
        vec_cnt++;
        if ({d_gnt, if_gnt, mem_en, d_rvalid, halted} !== 5'b00000) begin
            err_cnt++;
            $display("FAIL halt_drain_state got %b want 00000", {d_gnt, if_gnt, mem_en, d_rvalid, halted});
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            #2;
            vec_cnt++;
            if ({halted, d_gnt, if_gnt, mem_en} !== 4'b1000) begin
                err_cnt++;
                $display("FAIL halt_stuck cycle %0d got halted/gnt/en=%b want 1000", c,
                         {halted, d_gnt, if_gnt, mem_en});
            end
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_reset_inflight();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        d_req = 1'b1; d_we = 1'b0; d_addr = 10'd9;
        #2;
        vec_cnt++;
        if ({d_gnt, halted} !== 2'b10) begin
            err_cnt++;
            $display("FAIL post_reset_run got d_gnt=%b halted=%b want 1 0", d_gnt, halted);
        end
        #1;
        rst_n = 1'b0;
        tick();
        #2;
        vec_cnt++;
        if ({if_gnt, d_gnt, mem_en, mem_we, if_rvalid, d_rvalid, halted, if_rdata, d_rdata, mem_addr}
                !== '0) begin
            err_cnt++;
            $display("FAIL reset_inflight got ctrl=%b if_rdata=%h d_rdata=%h mem_addr=%h want all 0",
                     {if_gnt, d_gnt, mem_en, mem_we, if_rvalid, d_rvalid, halted},
                     if_rdata, d_rdata, mem_addr);
        end
        tick();
        idle_inputs();
        rst_n = 1'b1;
        tick();
        #2;
        vec_cnt++;
        if ({d_rvalid, if_rvalid, halted, d_rdata} !== {3'b000, 32'h0}) begin
            err_cnt++;
            $display("FAIL after_reset_quiet got d_rvalid=%b if_rvalid=%b halted=%b d_rdata=%h want 0 0 0 0",
                     d_rvalid, if_rvalid, halted, d_rdata);
        end
        tick();
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        bd_we = 1'b0; bd_addr = '0; bd_data = '0;
        idle_inputs();
        rst_n = 1'b0;
        #1;
        test_reset();
        test_fetch();
        test_starvation();
        test_store_load();
        test_flush();
        test_halt();
        test_reset_inflight();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
